// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   req_valid_x / req_ready_x    request handshake per requester (x = 0, 1)
//   req_func_x, req_a_x, req_b_x ALU function code and operands per requester
//   resp_valid_x / resp_ready_x  response handshake per requester
//   resp_data                    registered result, shared, qualified by resp_valid_x
//   alu_func, alu_in1, alu_in2   registered operands driven to the external ALU
//   alu_result                   combinational ALU output
//   busy                         high whenever an operation is in flight
//   ops_done                     completed-operation counter (wraps)
module alu_arbiter #(
    parameter int WIDTH      = 32,
    parameter int FUNC_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid_0,
    input  logic                  req_valid_1,
    output logic                  req_ready_0,
    output logic                  req_ready_1,
    input  logic [FUNC_WIDTH-1:0] req_func_0,
    input  logic [FUNC_WIDTH-1:0] req_func_1,
    input  logic [WIDTH-1:0]      req_a_0,
    input  logic [WIDTH-1:0]      req_a_1,
    input  logic [WIDTH-1:0]      req_b_0,
    input  logic [WIDTH-1:0]      req_b_1,
    output logic                  resp_valid_0,
    output logic                  resp_valid_1,
    input  logic                  resp_ready_0,
    input  logic                  resp_ready_1,
    output logic [WIDTH-1:0]      resp_data,
    output logic [FUNC_WIDTH-1:0] alu_func,
    output logic [WIDTH-1:0]      alu_in1,
    output logic [WIDTH-1:0]      alu_in2,
    input  logic [WIDTH-1:0]      alu_result,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;

    logic [FUNC_WIDTH-1:0] op_func;
    logic [WIDTH-1:0]      op_a;
    logic [WIDTH-1:0]      op_b;
    logic [WIDTH-1:0]      result;
    logic                  owner;
    logic                  last_grant;

    logic                  grant_valid;
    logic                  grant_sel;
    logic                  accept;
    logic                  owner_ready;

    // Arbitration and handshake outputs. A lone requester always wins;
    // on contention the port that did not win last time is chosen.
    always_comb begin
        grant_valid  = req_valid_0 | req_valid_1;
        grant_sel    = (req_valid_0 & req_valid_1) ? ~last_grant : req_valid_1;
        owner_ready  = owner ? resp_ready_1 : resp_ready_0;
        accept       = 1'b0;
        next_state   = state;
        req_ready_0  = 1'b0;
        req_ready_1  = 1'b0;
        resp_valid_0 = 1'b0;
        resp_valid_1 = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    accept      = 1'b1;
                    req_ready_0 = ~grant_sel;
                    req_ready_1 = grant_sel;
                    next_state  = EXEC;
                end
            end
            EXEC: begin
                next_state = RESP;
            end
            RESP: begin
                resp_valid_0 = ~owner;
                resp_valid_1 = owner;
                // Only the owner's ready can retire the response.
                if (owner_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_func    <= '0;
            op_a       <= '0;
            op_b       <= '0;
            result     <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            ops_done   <= '0;
        end else begin
            if (accept) begin
                op_func    <= grant_sel ? req_func_1 : req_func_0;
                op_a       <= grant_sel ? req_a_1 : req_a_0;
                op_b       <= grant_sel ? req_b_1 : req_b_0;
                owner      <= grant_sel;
                last_grant <= grant_sel;
            end
            if (state == EXEC) begin
                result <= alu_result;
            end
            if ((state == RESP) && owner_ready) begin
                ops_done <= ops_done + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // The ALU sees only registered operands, so its inputs stay stable
    // from accept until the next accept.
    assign alu_func  = op_func;
    assign alu_in1   = op_a;
    assign alu_in2   = op_b;
    assign resp_data = result;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural ALU and timing model
module tb_alu_arbiter;

    logic        clock;
    logic        reset;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [3:0]  req_func_0, req_func_1;
    logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
    logic        resp_valid_0, resp_valid_1;
    logic        resp_ready_0, resp_ready_1;
    logic [31:0] resp_data;
    logic [3:0]  alu_func;
    logic [31:0] alu_in1, alu_in2, alu_result;
    logic        busy;
    logic [15:0] ops_done;

    int checks = 0;
    int failures = 0;

    alu_arbiter #(.WIDTH(32), .FUNC_WIDTH(4), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_func_0(req_func_0), .req_func_1(req_func_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
        .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
        .resp_data(resp_data),
        .alu_func(alu_func), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_result(alu_result),
        .busy(busy), .ops_done(ops_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural ALU: RV32-style encoding {funct7[5], funct3}.
    function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0001: r = a << b[4:0];
            4'b0010: r = {31'b0, $signed(a) < $signed(b)};
            4'b0011: r = {31'b0, a < b};
            4'b0100: r = a ^ b;
            4'b0101: r = a >> b[4:0];
            4'b1101: r = $signed(a) >>> b[4:0];
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            default: r = a ^ ~b;
        endcase
        return r;
    endfunction

    always_comb alu_result = alu_ref(alu_func, alu_in1, alu_in2);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [31:0] sb[$];
    bit          m_ok = 0;
    bit          m_inflight;
    bit          m_owner;
    bit          m_last;
    int          m_age;
    logic [15:0] m_ops;
    logic [1:0]  m_v;
    logic [1:0]  m_exp_ready;
    logic [1:0]  m_exp_rv;
    bit          m_g;

    always @(negedge clock) begin
        m_v = {req_valid_1, req_valid_0};
        m_exp_ready = 2'b00;
        m_g = 1'b0;
        if (!m_inflight && m_v != 2'b00) begin
            m_g = (m_v == 2'b11) ? !m_last : m_v[1];
            m_exp_ready[m_g] = 1'b1;
        end
        m_exp_rv = 2'b00;
        if (m_inflight && m_age >= 2) m_exp_rv[m_owner] = 1'b1;

        if (m_ok) begin
            check("req_ready", {30'b0, req_ready_1, req_ready_0}, {30'b0, m_exp_ready});
            check("resp_valid", {30'b0, resp_valid_1, resp_valid_0}, {30'b0, m_exp_rv});
            check("busy", {31'b0, busy}, {31'b0, m_inflight});
            check("ops_done", {16'b0, ops_done}, {16'b0, m_ops});
            if (m_exp_rv != 2'b00) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: response expected but scoreboard holds nothing");
                end else begin
                    check("resp_data", resp_data, sb[0]);
                end
            end
        end

        if (reset) begin
            m_ok = 1;
            m_inflight = 0;
            m_owner = 0;
            m_last = 1;
            m_age = 0;
            m_ops = 0;
            sb.delete();
        end else if (m_ok) begin
            if (!m_inflight) begin
                if (m_v != 2'b00) begin
                    sb.push_back(m_g ? alu_ref(req_func_1, req_a_1, req_b_1)
                                     : alu_ref(req_func_0, req_a_0, req_b_0));
                    m_inflight = 1;
                    m_owner = m_g;
                    m_last = m_g;
                    m_age = 1;
                end
            end else if (m_age >= 2 && (m_owner ? resp_ready_1 : resp_ready_0)) begin
                void'(sb.pop_front());
                m_inflight = 0;
                m_ops = m_ops + 16'd1;
            end else begin
                m_age++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic do_reset;
        reset = 1;
        req_valid_0 = 0;
        req_valid_1 = 0;
        tick;
        reset = 0;
    endtask

    task automatic drive(input int p, input logic v, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req_valid_0 = v; req_func_0 = f; req_a_0 = a; req_b_0 = b;
        end else begin
            req_valid_1 = v; req_func_1 = f; req_a_1 = a; req_b_1 = b;
        end
    endtask

    task automatic wait_resp(input int p, output logic [31:0] d);
        int n = 0;
        settle;
        while (!(p == 1 ? resp_valid_1 : resp_valid_0) && n < 20) begin
            tick;
            n++;
        end
        if (n == 20) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout: port %0d gave no response within 20 cycles", p);
        end
        d = resp_data;
    endtask

    logic [31:0] d;
    int          order[$];
    bit          acc0, acc1;

    initial begin
        reset = 1;
        req_valid_0 = 0; req_valid_1 = 0;
        req_func_0 = 0; req_func_1 = 0;
        req_a_0 = 0; req_a_1 = 0; req_b_0 = 0; req_b_1 = 0;
        resp_ready_0 = 0; resp_ready_1 = 0;
        repeat (2) tick;
        reset = 0;

        // 1: single add with immediate response
        check("t1_reset_ops", {16'b0, ops_done}, 32'd0);
        check("t1_reset_busy", {31'b0, busy}, 32'd0);
        check("t1_reset_alu_func", {28'b0, alu_func}, 32'd0);
        drive(0, 1, 4'b0000, 32'd10, 32'd20);
        resp_ready_0 = 1;
        settle;
        check("t1_ready0_c0", {31'b0, req_ready_0}, 32'd1);
        tick;
        drive(0, 0, 4'b0000, 32'd0, 32'd0);
        settle;
        check("t1_resp_c1", {31'b0, resp_valid_0}, 32'd0);
        tick;
        check("t1_resp_c2", {31'b0, resp_valid_0}, 32'd1);
        check("t1_data", resp_data, 32'd30);
        tick;
        check("t1_busy_c3", {31'b0, busy}, 32'd0);
        check("t1_ops", {16'b0, ops_done}, 32'd1);

        // 2: simultaneous requests, port 0 first after reset
        do_reset;
        drive(0, 1, 4'b1000, 32'd10, 32'd20);
        drive(1, 1, 4'b1101, 32'hFFFFFFF6, 32'd1);
        resp_ready_0 = 1; resp_ready_1 = 1;
        settle;
        check("t2_ready0", {31'b0, req_ready_0}, 32'd1);
        check("t2_ready1", {31'b0, req_ready_1}, 32'd0);
        tick;
        drive(0, 0, 4'b0000, 32'd0, 32'd0);
        wait_resp(0, d);
        check("t2_data0", d, 32'hFFFFFFF6);
        check("t2_ready1_resp", {31'b0, req_ready_1}, 32'd0);
        tick;
        check("t2_ready1_idle", {31'b0, req_ready_1}, 32'd1);
        tick;
        drive(1, 0, 4'b0000, 32'd0, 32'd0);
        wait_resp(1, d);
        check("t2_data1", d, 32'hFFFFFFFB);
        check("t2_rv0", {31'b0, resp_valid_0}, 32'd0);
        tick;

        // 3: both continuously valid, round-robin order
        do_reset;
        drive(0, 1, 4'b0000, 32'd1, 32'd2);
        drive(1, 1, 4'b0000, 32'd3, 32'd4);
        order.delete();
        for (int i = 0; i < 12; i++) begin
            settle;
            if (req_ready_0) order.push_back(0);
            if (req_ready_1) order.push_back(1);
            tick;
        end
        drive(0, 0, 4'b0000, 32'd0, 32'd0);
        drive(1, 0, 4'b0000, 32'd0, 32'd0);
        check("t3_grant_count", order.size(), 32'd4);
        for (int i = 0; i < order.size(); i++) check("t3_grant_order", order[i], i % 2);
        check("t3_ops", {16'b0, ops_done}, 32'd4);
        tick;

        // 4: backpressure on port 0
        do_reset;
        drive(0, 1, 4'b0001, 32'd10, 32'd20);
        resp_ready_0 = 0;
        settle;
        tick;
        drive(0, 0, 4'b0000, 32'd0, 32'd0);
        drive(1, 1, 4'b0000, 32'd7, 32'd8);
        tick;
        for (int i = 0; i < 5; i++) begin
            settle;
            check("t4_rv0", {31'b0, resp_valid_0}, 32'd1);
            check("t4_data", resp_data, 32'h00A00000);
            check("t4_ready", {30'b0, req_ready_1, req_ready_0}, 32'd0);
            tick;
        end
        resp_ready_0 = 1;
        settle;
        check("t4_ops_before", {16'b0, ops_done}, 32'd0);
        tick;
        check("t4_ops_after", {16'b0, ops_done}, 32'd1);
        check("t4_ready1_idle", {31'b0, req_ready_1}, 32'd1);
        tick;
        drive(1, 0, 4'b0000, 32'd0, 32'd0);
        repeat (4) tick;
        check("t4_ops_final", {16'b0, ops_done}, 32'd2);

        // 5: reset while in EXEC
        do_reset;
        drive(0, 1, 4'b0000, 32'd5, 32'd6);
        settle;
        tick;
        drive(0, 0, 4'b0000, 32'd0, 32'd0);
        check("t5_busy_exec", {31'b0, busy}, 32'd1);
        reset = 1;
        tick;
        reset = 0;
        settle;
        check("t5_busy", {31'b0, busy}, 32'd0);
        check("t5_rv", {30'b0, resp_valid_1, resp_valid_0}, 32'd0);
        check("t5_ops", {16'b0, ops_done}, 32'd0);
        drive(0, 1, 4'b0100, 32'h0F0F0F0F, 32'h00FF00FF);
        drive(1, 1, 4'b0111, 32'h12345678, 32'hFFFF0000);
        settle;
        check("t5_ready0", {31'b0, req_ready_0}, 32'd1);
        check("t5_ready1", {31'b0, req_ready_1}, 32'd0);
        tick;
        drive(0, 0, 4'b0000, 32'd0, 32'd0);
        wait_resp(0, d);
        check("t5_data0", d, 32'h0FF00FF0);
        tick;
        tick;
        drive(1, 0, 4'b0000, 32'd0, 32'd0);
        wait_resp(1, d);
        check("t5_data1", d, 32'h12340000);
        tick;

        // 6: only port 1 requests, three times
        do_reset;
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 4'b0101, 32'hFFFFFFF6, 32'd1);
            settle;
            check("t6_ready1", {31'b0, req_ready_1}, 32'd1);
            tick;
            drive(1, 0, 4'b0000, 32'd0, 32'd0);
            wait_resp(1, d);
            check("t6_data", d, 32'h7FFFFFFB);
            check("t6_rv0", {31'b0, resp_valid_0}, 32'd0);
            tick;
        end
        check("t6_ops", {16'b0, ops_done}, 32'd3);

        // Random traffic with backpressure, withdrawals and occasional resets
        for (int i = 0; i < 600; i++) begin
            resp_ready_0 = ($urandom_range(0, 3) != 0);
            resp_ready_1 = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 79) == 0);
            settle;
            acc0 = req_valid_0 && req_ready_0;
            acc1 = req_valid_1 && req_ready_1;
            tick;
            if (acc0 || !req_valid_0 || $urandom_range(0, 7) == 0)
                drive(0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 40));
            if (acc1 || !req_valid_1 || $urandom_range(0, 7) == 0)
                drive(1, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom, $urandom);
        end
        reset = 0;
        drive(0, 0, 4'b0000, 32'd0, 32'd0);
        drive(1, 0, 4'b0000, 32'd0, 32'd0);
        resp_ready_0 = 1;
        resp_ready_1 = 1;
        repeat (6) tick;
        check("final_idle", {31'b0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU (4-bit func, two 32-bit operands, 32-bit result) between two requesters, e.g. the execute stage (port 0) and the address/branch unit (port 1).
- Accepts one operation at a time through a valid/ready handshake and arbitrates round-robin.
- Drives the ALU from registered operands and returns a registered result through a valid/ready response handshake.
- Counts completed operations for performance monitoring.

Parameters:
- WIDTH, 32, operand/result width.
- FUNC_WIDTH, 4, ALU function code width; the code is passed through unmodified.
- CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid_0 / req_valid_1  in  1  request present.
- req_ready_0 / req_ready_1  out  1  request accepted this cycle.
- req_func_0 / req_func_1  in  FUNC_WIDTH  ALU function code.
- req_a_0 / req_a_1  in  WIDTH  operand 1.
- req_b_0 / req_b_1  in  WIDTH  operand 2.
- resp_valid_0 / resp_valid_1  out  1  result available for that requester.
- resp_ready_0 / resp_ready_1  in  1  requester consumes the result.
- resp_data  out  WIDTH  result; shared by both ports and qualified by resp_valid_x.
- alu_func  out  FUNC_WIDTH  to ALU func.
- alu_in1  out  WIDTH  to ALU input_value1.
- alu_in2  out  WIDTH  to ALU input_value2.
- alu_result  in  WIDTH  from ALU output_value (combinational).
- busy  out  1  high in any state other than IDLE.
- ops_done  out  CNT_WIDTH  completed-operation count.

Behaviour:
- State machine: IDLE, EXEC, RESP.
- Registers: op_func, op_a, op_b, owner (1 bit), last_grant (1 bit), result, ops_done.
- Reset (synchronous):
  - state=IDLE; op_func/op_a/op_b=0, so the ALU sees func 0, 0, 0.
  - result=0; owner=0.
  - last_grant=1, so requester 0 has first priority.
  - ops_done=0; all req_ready/resp_valid=0; busy=0.
- IDLE, arbitration:
  - Only one valid: grant it.
  - Both valid: grant !last_grant.
  - None valid: stay in IDLE.
- IDLE, grant:
  - req_ready_g=1 combinationally in the same cycle (may depend on req_valid).
  - On the edge: latch func/a/b into op_*, owner=g, last_grant=g, go to EXEC.
  - req_ready is 0 outside IDLE and 0 for the non-granted port.
- alu_func/alu_in1/alu_in2 are always driven directly from op_*. They are stable for the whole operation.
- EXEC:
  - Lasts one cycle.
  - result<=alu_result; go to RESP.
- RESP:
  - resp_valid_owner=1 and resp_data=result.
  - The other port's resp_valid is 0.
  - Hold until resp_ready_owner=1. On that edge: ops_done++, go to IDLE.
  - resp_data and resp_valid must not change while stalled.
  - resp_ready of the non-owner is ignored.
- Latency and throughput:
  - Accept at cycle N gives resp_valid at cycle N+2.
  - With zero backpressure, one operation per 3 cycles; no new accept happens in the RESP cycle.
- ops_done wraps from 2^CNT_WIDTH-1 to 0.
- Function codes are not checked. Undefined codes pass through, and their result is whatever the ALU produces.
- Reset mid-operation (EXEC or RESP):
  - The in-flight operation is dropped and no response is produced.
  - All registers return to their reset values on the next edge.
  - The requester must reissue.
- A requester may deassert req_valid before it is granted without penalty. Once granted, the request is committed.

Test Plan:
1. Reset; req0 = add (0000), a=10, b=20; resp_ready_0=1. Required: req_ready_0=1 at cycle 0, resp_valid_0=1 at cycle 2 with resp_data=30, ops_done=1, busy back to 0 at cycle 3.
2. After reset, both valid in the same cycle: req0 = sub (1000) 10,20 and req1 = sra (1101) 0xFFFFFFF6,1. Required: req0 granted first and returns 0xFFFFFFF6; req_ready_1=0 until the state is back in IDLE; req1 is then granted and returns 0xFFFFFFFB on resp_valid_1 only.
3. Both ports continuously valid with add requests for 4 operations, resp_ready held at 1. Required: grant order 0,1,0,1; ops_done=4 after 12 cycles.
4. req0 = sll (0001) 10,20 with resp_ready_0=0 for 5 cycles. Required: resp_valid_0 stays high with resp_data=0x00A00000 held constant; both req_ready=0; after resp_ready_0 rises, ops_done increments exactly once.
5. Reset asserted during EXEC. Required: next cycle state=IDLE, no resp_valid, ops_done=0; with both requesters valid afterwards, requester 0 is granted first.
6. Only req1 valid, repeated 3 times with srl (0101) 0xFFFFFFF6,1. Required: port 1 is granted every time despite last_grant=1, each response is 0x7FFFFFFB, and resp_valid_0 never asserts.
